mux8_rr_sel_ctrl: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 8:1 single-bit mux (mux8_1).

---
 rtl/mux8_arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 36 +++
 rtl/mux8_rr_sel_ctrl.sv | 151 +++++++++++++++
 tb/tb_mux8_rr_sel_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the round-robin select controller of the 8:1 mux.
// Contents: requester count, select width, FSM state encodings and a
// rotate helper used by the round-robin picker.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Rotate an 8-bit vector right by s positions (bit s lands on bit 0).
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] d;
    d = {v, v} >> s;
    return d[7:0];
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for eight requesters.
// Ports:
//   req   in  8  request vector
//   ptr   in  3  highest-priority index for this search
//   idx   out 3  first set request found at or after ptr (wrapping 7 -> 0)
//   found out 1  at least one request is set
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] rot_s;
  logic [SEL_W-1:0] off_s;

  // Rotate so ptr becomes bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    rot_s = rotr8(req, ptr);
    off_s = 3'd0;
    found = |rot_s;
    // Scanning downward lets the lowest set bit be the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = i[SEL_W-1:0];
      end else begin
        off_s = off_s;
      end
    end
    // 3-bit addition wraps modulo 8 naturally.
    idx = ptr + off_s;
  end

endmodule

// File: rtl/mux8_rr_sel_ctrl.sv
// Round-robin arbiter and sequencer driving the select of a shared 8:1 mux.
// One requester at a time owns the mux for at most MAX_HOLD cycles; a dead
// cycle is inserted after every grant before a new select may be issued.
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset
//   en        in  1  allow new grants (a running grant always completes)
//   req       in  8  request vector, bit i asks for mux input i
//   mux_y     in  1  mux output fed back for capture
//   gnt       out 8  one-hot grant, zero when idle
//   sel       out 3  mux select, holds its last value when idle
//   sel_valid out 1  high while a grant is active
//   y_q       out 1  mux output captured on every GRANT cycle
module mux8_rr_sel_ctrl
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             mux_y,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             y_q
);

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic [SEL_W-1:0]  ptr_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic [SEL_W-1:0]  pick_idx_s;
  logic              pick_found_s;
  logic              start_s;
  logic              release_s;

  logic [N_REQ-1:0]  gnt_n_s;
  logic [SEL_W-1:0]  sel_n_s;
  logic              sel_valid_n_s;
  logic              y_q_n_s;
  logic [SEL_W-1:0]  ptr_n_s;
  logic [HOLD_W-1:0] hold_cnt_n_s;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Grant start and release conditions shared by both combinational processes.
  always_comb begin
    start_s   = en && pick_found_s;
    // Owner dropped its request, or it has used its last allowed cycle.
    release_s = !req[sel] || (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
  end

  // State register plus registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'd0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      gnt        <= 8'd0;
      sel        <= 3'd0;
      sel_valid  <= 1'b0;
      y_q        <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      ptr_r      <= ptr_n_s;
      hold_cnt_r <= hold_cnt_n_s;
      gnt        <= gnt_n_s;
      sel        <= sel_n_s;
      sel_valid  <= sel_valid_n_s;
      y_q        <= y_q_n_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_GRANT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_GRANT;
        end
      end
      ST_GAP:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of outputs, pointer and hold counter.
  always_comb begin
    gnt_n_s       = gnt;
    sel_n_s       = sel;
    sel_valid_n_s = sel_valid;
    y_q_n_s       = y_q;
    ptr_n_s       = ptr_r;
    hold_cnt_n_s  = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          gnt_n_s       = 8'd1 << pick_idx_s;
          sel_n_s       = pick_idx_s;
          sel_valid_n_s = 1'b1;
          hold_cnt_n_s  = {HOLD_W{1'b0}};
        end else begin
          gnt_n_s       = 8'd0;
          sel_valid_n_s = 1'b0;
        end
      end
      ST_GRANT: begin
        y_q_n_s = mux_y;
        if (release_s) begin
          gnt_n_s       = 8'd0;
          sel_valid_n_s = 1'b0;
          ptr_n_s       = sel + 3'd1;
          // Cleared rather than incremented so it never reaches MAX_HOLD.
          hold_cnt_n_s  = {HOLD_W{1'b0}};
        end else begin
          hold_cnt_n_s  = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        gnt_n_s       = 8'd0;
        sel_valid_n_s = 1'b0;
      end
      default: begin
        // Illegal encoding: drop any grant while returning to IDLE.
        gnt_n_s       = 8'd0;
        sel_valid_n_s = 1'b0;
        hold_cnt_n_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_mux8_rr_sel_ctrl.sv
// Self-checking bench for mux8_rr_sel_ctrl with MAX_HOLD=4, driving a
// behavioural 8:1 mux whose low inputs toggle at different rates.
module tb_mux8_rr_sel_ctrl;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       t0 = 1'b0, t1 = 1'b0, t2 = 1'b0, t3 = 1'b0;
  logic [7:0] in_v;
  logic       mux_y;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       sel_valid;
  logic       y_q;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner (-1 when nobody), cycles granted so far,
  // remaining forced-idle cycles, next search start, last issued select.
  int   m_owner, m_held, m_cool, m_start, m_sel;
  logic m_yq;

  always #5 clk = ~clk;
  always #10 t0 = ~t0;
  always #20 t1 = ~t1;
  always #40 t2 = ~t2;
  always #80 t3 = ~t3;
  assign in_v  = {4'b0110, t3, t2, t1, t0};
  assign mux_y = in_v[sel];

  mux8_rr_sel_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .mux_y     (mux_y),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .y_q       (y_q)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_cool = 0; m_start = 0; m_sel = 0; m_yq = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, from the inputs seen at that edge.
  task automatic model_edge();
    if (m_owner >= 0) begin
      m_held++;
      m_yq = in_v[m_sel];
      if (!req[m_owner] || m_held == MAX_HOLD) begin
        m_start = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (en && req != 8'd0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_start + k) % 8]) m_owner = (m_start + k) % 8;
      end
      m_sel  = m_owner;
      m_held = 0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    check("gnt", gnt, eg);
    check("sel", {5'd0, sel}, m_sel[7:0]);
    check("sel_valid", {7'd0, sel_valid}, {7'd0, (m_owner >= 0)});
    check("y_q", {7'd0, y_q}, {7'd0, m_yq});
    check("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; en = 1'b0; req = 8'd0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant on input 3
    en = 1'b1; req = 8'h08;
    tick(); tick(); tick();
    check("pre_reset_gnt", gnt, 8'h08);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 8'h00);
    check("async_rst_sel", {5'd0, sel}, 8'd0);
    check("async_rst_valid", {7'd0, sel_valid}, 8'd0);
    check("async_rst_yq", {7'd0, y_q}, 8'd0);
    model_reset();
    req = 8'd0;
    #3 rst_n = 1'b1;

    // Single request on 5 for three cycles, then the pointer sits at 6
    req = 8'h20;
    tick();
    check("single_gnt", gnt, 8'h20);
    check("single_sel", {5'd0, sel}, 8'd5);
    tick(); tick();
    req = 8'h00;
    tick();
    check("single_release", gnt, 8'h00);
    tick();
    req = 8'h41;
    tick();
    check("ptr6_gnt", gnt, 8'h40);

    // Wrap: after granting 6, requests on 7 and 0 are served 7 then 0
    req = 8'h00;
    tick(); tick(); tick();
    req = 8'h81;
    tick();
    check("wrap_first", gnt, 8'h80);
    for (int i = 0; i < 6; i++) tick();
    check("wrap_second", gnt, 8'h01);
    req = 8'h00;
    for (int i = 0; i < 6; i++) tick();

    // Saturation: every requester always asking
    req = 8'hFF;
    for (int i = 0; i < 70; i++) tick();
    req = 8'h00;
    for (int i = 0; i < 8; i++) tick();

    // Enable low during a grant on 2 with 1 and 2 requesting
    req = 8'h04;
    tick();
    check("en_gnt2", gnt, 8'h04);
    en = 1'b0; req = 8'h06;
    for (int i = 0; i < 10; i++) tick();
    check("en_low_idle", gnt, 8'h00);
    en = 1'b1;
    tick();
    check("en_high_gnt1", gnt, 8'h02);
    req = 8'h00;
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      en = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
